vec_io_sequencer: RTL and testbench
===================================

Name: vec_io_sequencer

Overview:
- Sequential stimulus/response front end for the team's technology-mapped combinational netlists (and_2/or_6/not_8 cell style).
- Receives an input vector serially over a valid/ready stream and drives it in parallel onto the netlist's primary inputs.
- After a programmable settle time, captures the netlist's primary outputs and returns them serially over a second valid/ready stream.
- Lets any mapped top (14 in / 8 out by default) be exercised through a 1-bit link on silicon or FPGA.

Parameters:
IN_W, 14, number of netlist primary inputs (width of dut_in)
OUT_W, 8, number of netlist primary outputs (width of dut_out)
SETTLE, 2, cycles dut_in is held stable before capture (>=1)
CNT_W, 16, width of vec_count

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
si_valid  input  1  serial-in bit valid
si_ready  output  1  serial-in ready; high only in LOAD and not in reset
si_data  input  1  serial-in bit, LSB of vector first
dut_in  output  IN_W  parallel drive to netlist primary inputs (registered)
dut_out  input  OUT_W  netlist primary outputs (combinational from dut_in)
so_valid  output  1  serial-out bit valid
so_ready  input  1  serial-out ready from sink
so_data  output  1  serial-out bit, LSB of captured word first
busy  output  1  high in SETTLE, CAPTURE, UNLOAD
vec_count  output  CNT_W  completed vectors (after last output bit accepted)

Behaviour:
- Reset (async assert, sync release): state=LOAD, dut_in=0, in_sr=0, out_sr=0, bit/settle counters=0, vec_count=0. si_ready=0 while rst=1. so_valid=0, so_data=0, busy=0.
- FSM states: LOAD, SETTLE, CAPTURE, UNLOAD.
- LOAD:
  - si_ready=1.
  - Each cycle with si_valid&si_ready, si_data shifts into in_sr; the first accepted bit ends in bit 0 and the IN_W-th in bit IN_W-1.
  - On the IN_W-th handshake, at the same edge: dut_in <= complete vector, settle counter=0, state -> SETTLE.
  - dut_in keeps the previous vector throughout LOAD. No partial vector is ever driven.
- SETTLE:
  - si_ready=0. Count SETTLE cycles.
  - After SETTLE cycles in this state, go to CAPTURE.
- CAPTURE:
  - Single cycle: out_sr <= dut_out, bit counter=0, state -> UNLOAD.
- UNLOAD:
  - so_valid=1, so_data=out_sr[0].
  - On so_valid&so_ready: out_sr shifts right by 1 and the bit counter increments.
  - On the OUT_W-th handshake: vec_count += 1 (wraps from all-ones to 0), state -> LOAD.
  - so_valid may stay high indefinitely while so_ready=0; so_data must stay stable until accepted.
- Latency: if the final input bit is accepted at edge E, dut_in changes at E, capture happens at edge E+SETTLE+1, and so_valid first rises after edge E+SETTLE+1.
- Back-to-back operation: LOAD is entered at the same edge as the last output handshake, so si_ready=1 in the very next cycle (no bubble).
- si_valid outside LOAD is ignored; no bits are lost because si_ready=0.
- so_ready outside UNLOAD is ignored.
- Reset mid-operation (any state): immediate return to reset values. The partial vector is discarded and dut_in returns to 0.
- All outputs are registered or decoded from state only. No combinational path from si_valid/so_ready to any output.
- Counter widths: $clog2 of IN_W and OUT_W.

Test Plan:
1. Reset release, bench model dut_out = dut_in[7:0]; send 0x1234 LSB-first with si_valid constantly high -> dut_in=0x1234 exactly after the 14th handshake. so_valid rises 3 cycles later (SETTLE=2) and emits bits 0,0,1,0,1,1,0,0 (0x34). vec_count=1.
2. Same vector with si_valid toggling 1/0 and so_ready low 5 cycles mid-unload -> identical bit stream, so_data stable while stalled, dut_in unchanged during the stall.
3. Two back-to-back vectors 0x3FFF then 0x0001 -> outputs 0xFF then 0x01. si_ready high the cycle after the last output bit of vector 1. dut_in stays 0x3FFF throughout the loading of vector 2.
4. Assert rst after 7 input bits, then again during UNLOAD -> dut_in=0, so_valid=0, vec_count=0 immediately; next full vector processes normally.
5. Force vec_count to 0xFFFF (or run 65536 vectors in a fast model), complete one vector -> vec_count=0x0000.
6. SETTLE=1 and SETTLE=5 builds -> so_valid rises 2 and 6 cycles respectively after the last input handshake.

Source files
------------

// File: rtl/vec_io_sequencer_if.sv
// Serial stimulus/response link plus parallel netlist drive/capture bundle for vec_io_sequencer.
// master = environment side (source/sink/netlist), slave = sequencer side.
interface vec_io_sequencer_if #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
);
  logic              si_valid;
  logic              si_ready;
  logic              si_data;
  logic [IN_W-1:0]   dut_in;
  logic [OUT_W-1:0]  dut_out;
  logic              so_valid;
  logic              so_ready;
  logic              so_data;
  logic              busy;
  logic [CNT_W-1:0]  vec_count;

  modport master (
    output si_valid, si_data, so_ready, dut_out,
    input  si_ready, so_valid, so_data, dut_in, busy, vec_count
  );

  modport slave (
    input  si_valid, si_data, so_ready, dut_out,
    output si_ready, so_valid, so_data, dut_in, busy, vec_count
  );
endinterface

// File: rtl/vec_io_sequencer.sv
// Serial-in vector -> parallel netlist drive -> capture after SETTLE -> serial-out result (LSB first).
// Latency: capture at E+SETTLE+1 after last input bit at edge E; both links stall freely on valid/ready.
module vec_io_sequencer #(
  parameter int IN_W   = 14,
  parameter int OUT_W  = 8,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic rst,
  vec_io_sequencer_if.slave io
);

  localparam int IC_W = (IN_W > 1)   ? $clog2(IN_W)   : 1;
  localparam int OC_W = (OUT_W > 1)  ? $clog2(OUT_W)  : 1;
  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IC_W-1:0] IN_LAST  = IC_W'(IN_W - 1);
  localparam logic [OC_W-1:0] OUT_LAST = OC_W'(OUT_W - 1);
  localparam logic [SC_W-1:0] SET_LAST = SC_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_UNLOAD  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [IN_W-1:0]   in_sr;
  logic [IN_W-1:0]   in_nxt;
  logic [OUT_W-1:0]  out_sr;
  logic [IN_W-1:0]   dut_in_q;
  logic [IC_W-1:0]   in_cnt;
  logic [OC_W-1:0]   out_cnt;
  logic [SC_W-1:0]   set_cnt;
  logic [CNT_W-1:0]  vec_cnt;

  logic              in_hs;
  logic              out_hs;
  logic              in_last;
  logic              out_last;
  logic              load_st;
  logic              unload_st;
  logic              busy_st;

  // New bit enters at the top so the first accepted bit ends up in bit 0.
  assign in_nxt   = (in_sr >> 1) | (IN_W'(io.si_data) << (IN_W - 1));
  assign in_last  = (in_cnt == IN_LAST);
  assign out_last = (out_cnt == OUT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_hs     = 1'b0;
    out_hs    = 1'b0;
    load_st   = 1'b0;
    unload_st = 1'b0;
    busy_st   = 1'b0;
    case (state)
      ST_LOAD: begin
        load_st = 1'b1;
        in_hs   = io.si_valid;
        if (in_hs && in_last) begin
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        busy_st = 1'b1;
        if (set_cnt == SET_LAST) begin
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        busy_st   = 1'b1;
        state_nxt = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        busy_st   = 1'b1;
        unload_st = 1'b1;
        out_hs    = io.so_ready;
        if (out_hs && out_last) begin
          state_nxt = ST_LOAD;
        end
      end
      default: begin
        state_nxt = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_sr    <= '0;
      out_sr   <= '0;
      dut_in_q <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      set_cnt  <= '0;
      vec_cnt  <= '0;
    end else begin
      if (in_hs) begin
        in_sr <= in_nxt;
        if (in_last) begin
          // Whole vector lands on the netlist in one edge; partial vectors never reach dut_in.
          dut_in_q <= in_nxt;
          in_cnt   <= '0;
          set_cnt  <= '0;
        end else begin
          in_cnt <= in_cnt + IC_W'(1);
        end
      end

      if (state == ST_SETTLE) begin
        set_cnt <= set_cnt + SC_W'(1);
      end

      if (state == ST_CAPTURE) begin
        out_sr  <= io.dut_out;
        out_cnt <= '0;
      end

      if (out_hs) begin
        out_sr <= out_sr >> 1;
        if (out_last) begin
          out_cnt <= '0;
          vec_cnt <= vec_cnt + CNT_W'(1);
        end else begin
          out_cnt <= out_cnt + OC_W'(1);
        end
      end
    end
  end

  // Outputs depend only on state and registers, never on si_valid/so_ready.
  assign io.si_ready  = load_st & ~rst;
  assign io.so_valid  = unload_st;
  assign io.so_data   = out_sr[0];
  assign io.busy      = busy_st;
  assign io.dut_in    = dut_in_q;
  assign io.vec_count = vec_cnt;

endmodule

// File: tb/tb_vec_io_sequencer.sv
// Bench for vec_io_sequencer: three builds (SETTLE 2/1/5, one with a 2-bit vec_count) behind a shared driver.
// Netlist model: dut_out = dut_in[7:0]; expected words go through a scoreboard queue.
module tb_vec_io_sequencer;

  localparam int S0 = 2;
  localparam int S1 = 1;
  localparam int S2 = 5;

  logic clk;
  logic rst;
  int   sel;
  int   cyc;
  int   errors;
  int   checks;

  logic v_si_valid;
  logic v_si_data;
  logic v_so_ready;

  logic        m_si_ready;
  logic        m_so_valid;
  logic        m_so_data;
  logic        m_busy;
  logic [13:0] m_dut_in;
  logic [31:0] m_vec_count;

  int          last_in_edge;
  logic [7:0]  exp_q[$];
  logic [31:0] exp_cnt[3];
  logic [13:0] prev_vec[3];

  typedef struct {
    logic [13:0] vec;
    logic [7:0]  exp;
    bit          toggle;
    int          stall;
  } row_t;

  row_t rows[5];

  vec_io_sequencer_if #(.IN_W(14), .OUT_W(8), .CNT_W(16)) if0 ();
  vec_io_sequencer_if #(.IN_W(14), .OUT_W(8), .CNT_W(2))  if1 ();
  vec_io_sequencer_if #(.IN_W(14), .OUT_W(8), .CNT_W(16)) if2 ();

  vec_io_sequencer #(.IN_W(14), .OUT_W(8), .SETTLE(S0), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .io(if0));
  vec_io_sequencer #(.IN_W(14), .OUT_W(8), .SETTLE(S1), .CNT_W(2))  u1 (.clk(clk), .rst(rst), .io(if1));
  vec_io_sequencer #(.IN_W(14), .OUT_W(8), .SETTLE(S2), .CNT_W(16)) u2 (.clk(clk), .rst(rst), .io(if2));

  assign if0.dut_out  = if0.dut_in[7:0];
  assign if1.dut_out  = if1.dut_in[7:0];
  assign if2.dut_out  = if2.dut_in[7:0];
  assign if0.si_valid = (sel == 0) && v_si_valid;
  assign if1.si_valid = (sel == 1) && v_si_valid;
  assign if2.si_valid = (sel == 2) && v_si_valid;
  assign if0.so_ready = (sel == 0) && v_so_ready;
  assign if1.so_ready = (sel == 1) && v_so_ready;
  assign if2.so_ready = (sel == 2) && v_so_ready;
  assign if0.si_data  = v_si_data;
  assign if1.si_data  = v_si_data;
  assign if2.si_data  = v_si_data;

  always_comb begin
    m_si_ready  = if0.si_ready;
    m_so_valid  = if0.so_valid;
    m_so_data   = if0.so_data;
    m_busy      = if0.busy;
    m_dut_in    = if0.dut_in;
    m_vec_count = 32'(if0.vec_count);
    if (sel == 1) begin
      m_si_ready  = if1.si_ready;
      m_so_valid  = if1.so_valid;
      m_so_data   = if1.so_data;
      m_busy      = if1.busy;
      m_dut_in    = if1.dut_in;
      m_vec_count = 32'(if1.vec_count);
    end else if (sel == 2) begin
      m_si_ready  = if2.si_ready;
      m_so_valid  = if2.so_valid;
      m_so_data   = if2.so_data;
      m_busy      = if2.busy;
      m_dut_in    = if2.dut_in;
      m_vec_count = 32'(if2.vec_count);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (sel=%0d t=%0t): got 0x%0h expected 0x%0h", name, sel, $time, act, exp);
    end
  endtask

  function automatic int lat_of(input int s);
    if (s == 1) return S1 + 1;
    if (s == 2) return S2 + 1;
    return S0 + 1;
  endfunction

  function automatic logic [31:0] mask_of(input int s);
    if (s == 1) return 32'h3;
    return 32'hFFFF;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_dut_in", 32'(m_dut_in), 32'h0);
    check("rst_so_valid", 32'(m_so_valid), 32'h0);
    check("rst_so_data", 32'(m_so_data), 32'h0);
    check("rst_vec_count", m_vec_count, 32'h0);
    check("rst_si_ready", 32'(m_si_ready), 32'h0);
    check("rst_busy", 32'(m_busy), 32'h0);
    for (int k = 0; k < 3; k++) begin
      exp_cnt[k]  = 32'h0;
      prev_vec[k] = 14'h0;
    end
    exp_q.delete();
    v_si_valid = 1'b0;
    v_so_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_si_ready", 32'(m_si_ready), 32'h1);
  endtask

  // Called and returns at a negedge; abort_after>=0 stops after that many accepted bits.
  task automatic send(input logic [13:0] v, input logic [7:0] e, input bit toggle, input int abort_after);
    int i;
    int g;
    logic [13:0] hold_seen;
    i = 0;
    g = 0;
    hold_seen = prev_vec[sel];
    while (i < 14 && g < 500) begin
      v_si_valid = toggle ? (g % 2 == 0) : 1'b1;
      v_si_data  = v[i];
      v_so_ready = toggle;
      if (m_dut_in !== prev_vec[sel]) hold_seen = m_dut_in;
      if (v_si_valid && m_si_ready) begin
        i++;
        last_in_edge = cyc + 1;
      end
      @(negedge clk);
      g++;
      if (abort_after >= 0 && i == abort_after) begin
        v_si_valid = 1'b0;
        v_so_ready = 1'b0;
        return;
      end
    end
    v_si_valid = 1'b0;
    v_so_ready = 1'b0;
    check("load_bits", 32'(i), 32'd14);
    check("dut_in_hold", 32'(hold_seen), 32'(prev_vec[sel]));
    check("dut_in_new", 32'(m_dut_in), 32'(v));
    check("busy_settle", 32'(m_busy), 32'h1);
    check("si_ready_settle", 32'(m_si_ready), 32'h0);
    prev_vec[sel] = v;
    exp_q.push_back(e);
  endtask

  task automatic recv(input int stall, input int abort_after, input bit noise);
    logic [7:0]  got;
    logic [7:0]  exp;
    logic        sd_hold;
    logic [13:0] di_hold;
    int b;
    int g;
    int st;
    int stall_bad;
    got = 8'h0;
    exp = 8'h0;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'h0, 32'h1);
      return;
    end
    exp = exp_q.pop_front();
    v_si_valid = noise;
    v_si_data  = 1'b1;
    g = 0;
    while (!m_so_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!m_so_valid) begin
      check("so_valid_timeout", 32'h0, 32'h1);
      v_si_valid = 1'b0;
      return;
    end
    check("so_valid_latency", 32'(cyc - last_in_edge), 32'(lat_of(sel)));
    b = 0;
    g = 0;
    st = 0;
    stall_bad = 0;
    sd_hold = 1'b0;
    di_hold = 14'h0;
    while (b < 8 && g < 500) begin
      if (b == 3 && st < stall) begin
        v_so_ready = 1'b0;
        if (st == 0) begin
          sd_hold = m_so_data;
          di_hold = m_dut_in;
        end else if (m_so_data !== sd_hold || m_dut_in !== di_hold || m_so_valid !== 1'b1) begin
          stall_bad++;
        end
        st++;
      end else begin
        v_so_ready = 1'b1;
      end
      if (v_so_ready && m_so_valid) begin
        got[b] = m_so_data;
        b++;
      end
      @(negedge clk);
      g++;
      if (abort_after >= 0 && b == abort_after) begin
        v_so_ready = 1'b0;
        v_si_valid = 1'b0;
        return;
      end
    end
    v_so_ready = 1'b0;
    v_si_valid = 1'b0;
    check("unload_bits", 32'(b), 32'd8);
    if (stall > 0) check("stall_hold", 32'(stall_bad), 32'h0);
    check("out_word", 32'(got), 32'(exp));
    exp_cnt[sel] = (exp_cnt[sel] + 32'h1) & mask_of(sel);
    check("vec_count", m_vec_count, exp_cnt[sel]);
    check("si_ready_no_bubble", 32'(m_si_ready), 32'h1);
    check("so_valid_done", 32'(m_so_valid), 32'h0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    sel = 0;
    last_in_edge = 0;
    v_si_valid = 1'b0;
    v_si_data  = 1'b0;
    v_so_ready = 1'b0;
    rst = 1'b1;

    rows[0] = '{vec: 14'h1234, exp: 8'h34, toggle: 1'b0, stall: 0};
    rows[1] = '{vec: 14'h1234, exp: 8'h34, toggle: 1'b1, stall: 5};
    rows[2] = '{vec: 14'h3FFF, exp: 8'hFF, toggle: 1'b0, stall: 0};
    rows[3] = '{vec: 14'h0001, exp: 8'h01, toggle: 1'b0, stall: 0};
    rows[4] = '{vec: 14'h2A55, exp: 8'h55, toggle: 1'b1, stall: 2};

    repeat (2) @(negedge clk);
    do_reset();
    @(negedge clk);

    // Table: basic, throttled/stalled, back-to-back all-ones then 1, mixed pattern.
    for (int r = 0; r < 5; r++) begin
      send(rows[r].vec, rows[r].exp, rows[r].toggle, -1);
      recv(rows[r].stall, -1, rows[r].toggle);
    end

    // Reset with a partial vector loaded, then reset during unload.
    send(14'h0ABC, 8'hBC, 1'b0, 7);
    do_reset();
    @(negedge clk);
    send(14'h0ABC, 8'hBC, 1'b0, -1);
    recv(0, 3, 1'b0);
    do_reset();
    @(negedge clk);
    send(14'h1F0F, 8'h0F, 1'b0, -1);
    recv(0, -1, 1'b0);

    // SETTLE=1 build with 2-bit counter: four vectors wrap vec_count back to 0.
    sel = 1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      logic [13:0] v;
      v = 14'h00A5 ^ 14'(k * 14'h0123);
      send(v, v[7:0], 1'b0, -1);
      recv(0, -1, 1'b0);
    end

    // SETTLE=5 build: longer settle latency.
    sel = 2;
    @(negedge clk);
    send(14'h2C3D, 8'h3D, 1'b0, -1);
    recv(1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
